acc_core_p: RTL and testbench
=============================

# acc_core_p

Parametrised accumulator processor core, the successor to the fixed 8-bit Fibonacci datapath. It combines the datapath and its own multi-cycle control FSM in one block: PC, IR, ACC, ROUT, carry flag, internal data RAM and ALU. Data and address widths are generic. It adds carry-based branching, a halt state, and valid/ready handshakes on the input and output ports. Instruction memory is external, so the same core runs any program image.

## Interface
- `DW`, 8: data width (ACC, RAM word, ROUT, `data_in`).
- `AW`, 8: address width (PC, RAM address, operand field); RAM depth is 2**AW.
- `IW`, 4+AW: instruction width, derived and not overridden; format is {opcode[3:0], operand[AW-1:0]}.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `imem_addr`  out  AW  instruction address (equals PC).
- `imem_data`  in  IW  instruction word; combinational read of `imem_addr`.
- `data_in`  in  DW  input data for IN.
- `in_valid`  in  1  `data_in` is valid.
- `in_ready`  out  1  core is consuming `data_in`.
- `data_out`  out  DW  ROUT register.
- `out_valid`  out  1  `data_out` holds an unconsumed value.
- `out_ready`  in  1  sink accepts `data_out`.
- `halted`  out  1  core is in HALT.
- `opcode`  out  4  IR[IW-1:AW], for debug.
- `acc_zero`  out  1  ACC == 0.
- `carry`  out  1  carry flag.

## Operation
- Opcodes and actions (`op` is the operand field):
  - 0x0 NOP: no action.
  - 0x1 LDI: ACC = `op`, zero-extended, or its low DW bits if AW > DW.
  - 0x2 LDM: ACC = RAM[`op`].
  - 0x3 STM: RAM[`op`] = ACC.
  - 0x4 ADD: {C, ACC} = ACC + RAM[`op`].
  - 0x5 SUB: ACC = ACC − RAM[`op`]; C = borrow (ACC < RAM).
  - 0x6 AND and 0x7 OR: bitwise with RAM[`op`]; C unchanged.
  - 0x8 IN: ACC = `data_in`.
  - 0x9 OUT: ROUT = ACC.
  - 0xA JMP: PC = `op`.
  - 0xB JZ: PC = `op` if ACC == 0.
  - 0xC JC: PC = `op` if C == 1.
  - 0xF HLT: enter HALT.
  - 0xD and 0xE: execute as NOP.
- Only ADD and SUB write C. JZ tests ACC as it stands before the branch.
- RAM: synchronous write, asynchronous read, no reset. Contents are undefined after `clr`.
- FSM states:
  - FETCH: IR ← `imem_data`; PC ← PC+1 mod 2**AW; go to EXEC.
  - EXEC: perform the opcode action, then go to FETCH, except:
    - IN with `in_valid`=0 stays in EXEC with `in_ready`=1; the instruction completes in the cycle `in_valid`=1.
    - OUT loads ROUT and goes to OUT_WAIT.
    - HLT goes to HALT.
  - OUT_WAIT: `out_valid`=1. Go to FETCH in the cycle `out_valid` && `out_ready`.
  - HALT: remains there until `clr`; `halted`=1; no state changes.
- `in_ready` is high only in EXEC while IR holds IN.

## Timing
- Reset values: PC=0, IR=0, ACC=0, ROUT=0, C=0, state FETCH, `out_valid`=0, `in_ready`=0, `halted`=0. Derived outputs after reset: `imem_addr`=0, `opcode`=0, `acc_zero`=1.
- `clr` has priority over every other event, including a mid-handshake OUT_WAIT (the pending output is dropped) and a stalled IN.
- Cycles per instruction:
  - Most instructions take 2 (FETCH + EXEC).
  - IN takes 2 + cycles waiting for `in_valid`.
  - OUT takes at least 3 (FETCH, EXEC, one OUT_WAIT cycle with `out_ready`=1).
- A branch target overwrites the PC+1 value written in FETCH. PC wraps from 2**AW−1 to 0.
- STM followed by LDM to the same address returns the new value, because the write commits at the STM EXEC edge.
- `data_out` is stable while `out_valid`=1. `data_out` and ROUT persist after the transfer.

## Structure
- Package `acc_pkg`: opcode enum (4-bit), FSM state enum, and the ALU op enum (ADD/SUB/AND/OR).
- Sub-module `acc_alu`: combinational, parametrised by DW; inputs a, b, op; outputs DW-bit result and carry/borrow.
- RAM, registers and FSM live in `acc_core_p`.

## Test plan
- Reset: drive `clr` for 2 cycles mid-program → next cycle PC=0, ACC=0, `out_valid`=0, `halted`=0.
- Fibonacci (DW=8): program with LDI/STM/LDM/ADD/OUT/JC, `out_ready` tied 1 → outputs 0,1,1,2,3,5,8,13,21,34,55,89,144,233. Then 233+144 sets C=1 and ACC=121; JC branches to HLT; `halted`=1.
- Output backpressure: OUT with ACC=0x2A, `out_ready` low for 5 cycles → `out_valid`=1 and `data_out`=0x2A held for those 5 cycles; PC does not advance; FETCH follows the first `out_ready` cycle.
- Input stall: IN with `in_valid` low 3 cycles, then `data_in`=0x5C → `in_ready` high for 4 cycles; ACC=0x5C after the transfer edge.
- Branch and flags: SUB 3−5 → ACC=0xFE, C=1; JZ not taken; JC taken to the operand address. PC at 2**AW−1 with NOP → wraps to 0.
- Parametrisation: DW=16, AW=6 → ADD 0xFFFF+1 gives ACC=0, C=1, `acc_zero`=1; LDI operand 0x3F loads 0x003F.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the accumulator core: instruction opcodes, control states
// and the reduced operation set understood by the ALU.
package acc_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LDI    = 4'h1,
        OP_LDM    = 4'h2,
        OP_STM    = 4'h3,
        OP_ADD    = 4'h4,
        OP_SUB    = 4'h5,
        OP_AND    = 4'h6,
        OP_OR     = 4'h7,
        OP_IN     = 4'h8,
        OP_OUT    = 4'h9,
        OP_JMP    = 4'hA,
        OP_JZ     = 4'hB,
        OP_JC     = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_OUT_WAIT,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_op_e;

    function automatic alu_op_e alu_op_of(input opcode_e op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/acc_core_p_if.sv
// Instruction fetch, input/output handshakes and debug status of the core.
interface acc_core_p_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    localparam int IW = 4 + AW;

    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;
    logic          halted;
    logic [3:0]    opcode;
    logic          acc_zero;
    logic          carry;

    modport master (
        output imem_addr, in_ready, data_out, out_valid, halted, opcode, acc_zero, carry,
        input  imem_data, data_in, in_valid, out_ready
    );

    modport slave (
        input  imem_addr, in_ready, data_out, out_valid, halted, opcode, acc_zero, carry,
        output imem_data, data_in, in_valid, out_ready
    );
endinterface

// File: rtl/acc_alu.sv
// Combinational ALU; carry holds the add carry-out or the subtract borrow.
module acc_alu
    import acc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_e       op,
    output logic [DW-1:0] result,
    output logic          carry
);
    logic [DW:0] sum;
    logic [DW:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        // Top bit of the zero-extended difference is set exactly when a < b.
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: {carry, result} = sum;
            ALU_SUB: {carry, result} = diff;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: ;
        endcase
    end
endmodule

// File: rtl/acc_core_p.sv
// Multi-cycle accumulator core: FETCH/EXEC control, PC, IR, ACC, ROUT, carry
// flag and a local asynchronous-read data RAM; program memory is external.
module acc_core_p
    import acc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input logic         clk,
    input logic         clr,
    acc_core_p_if.master bus
);
    localparam int IW = 4 + AW;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] rout_q, rout_d;
    logic          c_q, c_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          halted_q, halted_d;

    logic [DW-1:0] ram [2**AW];
    logic          ram_we;

    opcode_e       ir_op;
    logic [AW-1:0] ir_arg;
    logic [DW-1:0] ram_rd;
    logic [DW-1:0] alu_res;
    logic          alu_c;

    assign ir_op  = opcode_e'(ir_q[IW-1:AW]);
    assign ir_arg = ir_q[AW-1:0];
    assign ram_rd = ram[ir_arg];

    acc_alu #(.DW(DW)) u_alu (
        .a      (acc_q),
        .b      (ram_rd),
        .op     (alu_op_of(ir_op)),
        .result (alu_res),
        .carry  (alu_c)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        rout_d  = rout_q;
        c_d     = c_q;
        ram_we  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.imem_data;
                pc_d    = pc_q + AW'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (ir_op)
                    OP_LDI: acc_d = DW'(ir_arg);
                    OP_LDM: acc_d = ram_rd;
                    OP_STM: ram_we = 1'b1;
                    OP_ADD, OP_SUB: begin
                        acc_d = alu_res;
                        c_d   = alu_c;
                    end
                    OP_AND, OP_OR: acc_d = alu_res;
                    OP_IN: begin
                        if (bus.in_valid) acc_d = bus.data_in;
                        else              state_d = ST_EXEC;
                    end
                    OP_OUT: begin
                        rout_d  = acc_q;
                        state_d = ST_OUT_WAIT;
                    end
                    OP_JMP: pc_d = ir_arg;
                    OP_JZ:  if (acc_q == '0) pc_d = ir_arg;
                    OP_JC:  if (c_q) pc_d = ir_arg;
                    OP_HLT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            ST_OUT_WAIT: if (bus.out_ready) state_d = ST_FETCH;
            default: ;
        endcase
        // Status outputs are registered from the upcoming state so they align with it.
        out_valid_d = (state_d == ST_OUT_WAIT);
        in_ready_d  = (state_d == ST_EXEC) && (opcode_e'(ir_d[IW-1:AW]) == OP_IN);
        halted_d    = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            rout_q      <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            rout_q      <= rout_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            halted_q    <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !clr) ram[ir_arg] <= acc_q;
    end

    assign bus.imem_addr = pc_q;
    assign bus.data_out  = rout_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.halted    = halted_q;
    assign bus.opcode    = ir_q[IW-1:AW];
    assign bus.acc_zero  = (acc_q == '0);
    assign bus.carry     = c_q;
endmodule

// File: tb/tb_acc_core_p.sv
// Bench for acc_core_p: directed handshake/branch/reset cases, Fibonacci,
// a 16-bit/6-bit instance and random programs against an ISA-level model.
module tb_acc_core_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr, clr2;
    acc_core_p_if #(.DW(8),  .AW(8)) b1();
    acc_core_p_if #(.DW(16), .AW(6)) b2();

    acc_core_p #(.DW(8),  .AW(8)) dut1 (.clk(clk), .clr(clr),  .bus(b1));
    acc_core_p #(.DW(16), .AW(6)) dut2 (.clk(clk), .clr(clr2), .bus(b2));

    logic [31:0] prog [256];
    assign b1.imem_data = prog[b1.imem_addr][11:0];
    assign b2.imem_data = prog[8'(b2.imem_addr)][9:0];

    int checks = 0;
    int passed = 0;
    int unsigned in_q[$];
    int unsigned exp_out[$];
    int unsigned got[$];
    int unsigned exp_pc, exp_acc, exp_c, exp_cyc;
    int cyc;
    int unsigned fib_ref[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [31:0] enc(input int op, input int arg, input int aw);
        return (op << aw) | arg;
    endfunction

    task automatic clear_prog();
        for (int a = 0; a < 256; a++) prog[a] = 32'hF00;
    endtask

    // Instruction-level reference: one loop iteration per instruction, cycle
    // cost taken from the CPI rules assuming no handshake stalls.
    task automatic model_run(input int aw, input int dw);
        int unsigned ram [256];
        int unsigned pc, acc, c, amask, dmask, ins, op, arg, ii, s;
        bit done;
        amask = (1 << aw) - 1;
        dmask = (1 << dw) - 1;
        pc = 0; acc = 0; c = 0; ii = 0; done = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 0;
        exp_out.delete();
        exp_cyc = 0;
        for (int step = 0; step < 5000 && !done; step++) begin
            ins = prog[pc];
            op  = (ins >> aw) & 15;
            arg = ins & amask;
            pc  = (pc + 1) & amask;
            exp_cyc += 2;
            case (op)
                1:  acc = arg & dmask;
                2:  acc = ram[arg];
                3:  ram[arg] = acc;
                4:  begin s = acc + ram[arg]; c = (s >> dw) & 1; acc = s & dmask; end
                5:  begin c = (acc < ram[arg]) ? 1 : 0; acc = (acc - ram[arg]) & dmask; end
                6:  acc = acc & ram[arg];
                7:  acc = acc | ram[arg];
                8:  begin acc = (ii < in_q.size()) ? (in_q[ii] & dmask) : 0; ii++; end
                9:  begin exp_out.push_back(acc); exp_cyc++; end
                10: pc = arg;
                11: if (acc == 0) pc = arg;
                12: if (c == 1) pc = arg;
                15: done = 1'b1;
                default: ;
            endcase
        end
        exp_pc = pc; exp_acc = acc; exp_c = c;
    endtask

    task automatic run1(input string tag, input int maxc, input bit rnd);
        int unsigned ii, oi;
        ii = 0; oi = 0; cyc = 0;
        while (!b1.halted && cyc < maxc) begin
            b1.in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            b1.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            b1.data_in   = (ii < in_q.size()) ? 8'(in_q[ii]) : 8'h00;
            #1;
            if (b1.in_valid && b1.in_ready) ii++;
            if (b1.out_valid && b1.out_ready) begin
                if (oi < exp_out.size()) chk({tag, "_out"}, b1.data_out, exp_out[oi]);
                else chk({tag, "_out_extra"}, oi, exp_out.size());
                oi++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_halted"}, b1.halted, 1'b1);
        chk({tag, "_nout"}, oi, exp_out.size());
        chk({tag, "_pc"}, b1.imem_addr, exp_pc);
        chk({tag, "_carry"}, b1.carry, exp_c);
        chk({tag, "_acc_zero"}, b1.acc_zero, exp_acc == 0);
    endtask

    task automatic wait_ov(input string tag, input int maxc);
        for (int i = 0; i < maxc && !b1.out_valid; i++) tick();
        chk(tag, b1.out_valid, 1'b1);
    endtask

    initial begin
        clr = 1'b1; clr2 = 1'b1;
        b1.data_in = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
        b2.data_in = '0; b2.in_valid = 1'b0; b2.out_ready = 1'b1;
        clear_prog();
        do_reset();
        chk("rst_imem_addr", b1.imem_addr, 0);
        chk("rst_opcode", b1.opcode, 0);
        chk("rst_acc_zero", b1.acc_zero, 1);
        chk("rst_carry", b1.carry, 0);
        chk("rst_out_valid", b1.out_valid, 0);
        chk("rst_in_ready", b1.in_ready, 0);
        chk("rst_halted", b1.halted, 0);
        chk("rst_data_out", b1.data_out, 0);

        // Fibonacci: p at RAM[1], c at RAM[0]; output c, stop on carry.
        clear_prog();
        prog[0]  = enc(1, 1, 8);  prog[1]  = enc(3, 1, 8);
        prog[2]  = enc(1, 0, 8);  prog[3]  = enc(3, 0, 8);
        prog[4]  = enc(2, 0, 8);  prog[5]  = enc(9, 0, 8);
        prog[6]  = enc(4, 1, 8);  prog[7]  = enc(12, 14, 8);
        prog[8]  = enc(3, 2, 8);  prog[9]  = enc(2, 0, 8);
        prog[10] = enc(3, 1, 8);  prog[11] = enc(2, 2, 8);
        prog[12] = enc(3, 0, 8);  prog[13] = enc(10, 4, 8);
        prog[14] = enc(15, 0, 8);
        in_q.delete();
        model_run(8, 8);
        exp_out.delete();
        foreach (fib_ref[i]) exp_out.push_back(fib_ref[i]);
        do_reset();
        run1("fib", 2000, 1'b0);
        chk("fib_cycles", cyc, exp_cyc);
        chk("fib_carry_const", b1.carry, 1);
        chk("fib_acc_nonzero", b1.acc_zero, 0);

        // Reset while an output is pending.
        do_reset();
        b1.out_ready = 1'b0;
        wait_ov("mid_wait0", 100);
        b1.out_ready = 1'b1;
        tick();
        b1.out_ready = 1'b0;
        wait_ov("mid_wait1", 100);
        chk("mid_pending_val", b1.data_out, 1);
        do_reset();
        chk("mid_rst_pc", b1.imem_addr, 0);
        chk("mid_rst_out_valid", b1.out_valid, 0);
        chk("mid_rst_data_out", b1.data_out, 0);
        chk("mid_rst_acc_zero", b1.acc_zero, 1);
        chk("mid_rst_halted", b1.halted, 0);
        chk("mid_rst_opcode", b1.opcode, 0);

        // Output backpressure.
        clear_prog();
        prog[0] = enc(1, 8'h2A, 8); prog[1] = enc(9, 0, 8);
        prog[2] = enc(1, 8'h11, 8); prog[3] = enc(15, 0, 8);
        b1.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", b1.out_valid, 1);
            chk("bp_data_out", b1.data_out, 8'h2A);
            chk("bp_pc_hold", b1.imem_addr, 2);
            tick();
        end
        b1.out_ready = 1'b1;
        chk("bp_valid_at_ready", b1.out_valid, 1);
        tick();
        chk("bp_valid_drop", b1.out_valid, 0);
        chk("bp_rout_persist", b1.data_out, 8'h2A);
        chk("bp_fetch_pc", b1.imem_addr, 2);
        tick();
        chk("bp_next_pc", b1.imem_addr, 3);
        chk("bp_next_opcode", b1.opcode, 1);

        // Input stall.
        clear_prog();
        prog[0] = enc(8, 0, 8); prog[1] = enc(9, 0, 8); prog[2] = enc(15, 0, 8);
        b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.data_in = 8'h00;
        do_reset();
        chk("in_fetch_not_ready", b1.in_ready, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("in_stall_ready", b1.in_ready, 1);
            chk("in_stall_pc", b1.imem_addr, 1);
            tick();
        end
        b1.data_in = 8'h5C; b1.in_valid = 1'b1;
        chk("in_xfer_ready", b1.in_ready, 1);
        tick();
        b1.in_valid = 1'b0; b1.data_in = 8'h00;
        chk("in_after_ready", b1.in_ready, 0);
        chk("in_acc_nonzero", b1.acc_zero, 0);
        tick();
        tick();
        chk("in_out_valid", b1.out_valid, 1);
        chk("in_acc_value", b1.data_out, 8'h5C);

        // Branches, flags and PC wrap.
        clear_prog();
        prog[0] = enc(1, 3, 8);   prog[1] = enc(3, 0, 8);
        prog[2] = enc(1, 5, 8);   prog[3] = enc(3, 1, 8);
        prog[4] = enc(2, 0, 8);   prog[5] = enc(5, 1, 8);
        prog[6] = enc(11, 20, 8); prog[7] = enc(12, 9, 8);
        prog[9] = enc(13, 0, 8);  prog[10] = enc(9, 0, 8);
        prog[11] = enc(10, 255, 8); prog[255] = enc(0, 0, 8);
        b1.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) tick();
        chk("br_sub_borrow", b1.carry, 1);
        chk("br_sub_nonzero", b1.acc_zero, 0);
        tick(); tick();
        chk("br_jz_not_taken", b1.imem_addr, 7);
        tick(); tick();
        chk("br_jc_taken", b1.imem_addr, 9);
        tick(); tick();
        chk("br_rsvd_nop", b1.imem_addr, 10);
        tick(); tick();
        chk("br_out_valid", b1.out_valid, 1);
        chk("br_sub_result", b1.data_out, 8'hFE);
        tick(); tick(); tick();
        chk("br_jmp_top", b1.imem_addr, 255);
        tick();
        chk("br_pc_wrap", b1.imem_addr, 0);
        chk("br_wrap_opcode", b1.opcode, 0);
        chk("br_not_halted", b1.halted, 0);

        // 16-bit data, 6-bit address instance.
        clear_prog();
        prog[0] = enc(1, 6'h3F, 6); prog[1] = enc(9, 0, 6);
        prog[2] = enc(1, 1, 6);     prog[3] = enc(3, 0, 6);
        prog[4] = enc(1, 0, 6);     prog[5] = enc(5, 0, 6);
        prog[6] = enc(3, 1, 6);     prog[7] = enc(9, 0, 6);
        prog[8] = enc(1, 1, 6);     prog[9] = enc(4, 1, 6);
        prog[10] = enc(15, 0, 6);
        in_q.delete();
        model_run(6, 16);
        clr2 = 1'b1; tick(); tick(); clr2 = 1'b0;
        got.delete();
        cyc = 0;
        while (!b2.halted && cyc < 500) begin
            if (b2.out_valid && b2.out_ready) got.push_back(32'(b2.data_out));
            tick();
            cyc++;
        end
        chk("w16_halted", b2.halted, 1);
        chk("w16_cycles", cyc, exp_cyc);
        chk("w16_nout", got.size(), 2);
        if (got.size() >= 2) begin
            chk("w16_ldi_zext", got[0], 32'h003F);
            chk("w16_sub_wrap", got[1], 32'hFFFF);
        end
        chk("w16_add_zero", b2.acc_zero, 1);
        chk("w16_add_carry", b2.carry, 1);
        chk("w16_pc", b2.imem_addr, exp_pc);

        // Random forward-branching programs with random handshakes.
        for (int r = 0; r < 6; r++) begin
            int op, arg;
            clear_prog();
            for (int i = 0; i < 8; i++) begin
                prog[2*i]   = enc(1, $urandom_range(0, 255), 8);
                prog[2*i+1] = enc(3, i, 8);
            end
            for (int a = 16; a < 40; a++) begin
                op = $urandom_range(0, 14);
                if (op >= 2 && op <= 7)        arg = $urandom_range(0, 7);
                else if (op >= 10 && op <= 12) arg = $urandom_range(a + 1, 40);
                else                           arg = $urandom_range(0, 255);
                prog[a] = enc(op, arg, 8);
            end
            in_q.delete();
            for (int i = 0; i < 32; i++) in_q.push_back($urandom_range(0, 255));
            model_run(8, 8);
            do_reset();
            run1("rnd", 4000, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
